wb_arbiter: RTL

Writeback arbiter that sits directly upstream of the register file and drives its rd write port (address, data, write enable).
- Merges the single-cycle ALU result path with a long-latency result path (loads, multiply/divide) through a 2-entry buffer.
- Keeps a pending-write scoreboard so the hazard logic can stall on registers whose long-latency result has not yet reached the register file.

---
 rtl/wb_arbiter_if.sv | 47 ++++
 rtl/wb_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter signal bundle: ALU result, long-latency result handshake,
// issue tracking, hazard query and the register-file rd write port.
interface wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            i_alu_wren;
    logic [4:0]      i_alu_rd_addr;
    logic [XLEN-1:0] i_alu_rd_data;

    logic            i_ll_valid;
    logic            o_ll_ready;
    logic [4:0]      i_ll_rd_addr;
    logic [XLEN-1:0] i_ll_rd_data;

    logic            i_ll_issue;
    logic [4:0]      i_ll_issue_rd;

    logic [4:0]      i_rs1_addr;
    logic [4:0]      i_rs2_addr;
    logic            o_rs1_pending;
    logic            o_rs2_pending;

    logic            o_rd_wren;
    logic [4:0]      o_rd_addr;
    logic [XLEN-1:0] o_rd_data;
    logic [1:0]      o_ll_count;

    // Pipeline side drives results, issues and hazard queries.
    modport master (
        output i_alu_wren, i_alu_rd_addr, i_alu_rd_data,
        output i_ll_valid, i_ll_rd_addr, i_ll_rd_data,
        output i_ll_issue, i_ll_issue_rd,
        output i_rs1_addr, i_rs2_addr,
        input  o_ll_ready, o_rs1_pending, o_rs2_pending,
        input  o_rd_wren, o_rd_addr, o_rd_data, o_ll_count
    );

    // Arbiter side.
    modport slave (
        input  i_alu_wren, i_alu_rd_addr, i_alu_rd_data,
        input  i_ll_valid, i_ll_rd_addr, i_ll_rd_data,
        input  i_ll_issue, i_ll_issue_rd,
        input  i_rs1_addr, i_rs2_addr,
        output o_ll_ready, o_rs1_pending, o_rs2_pending,
        output o_rd_wren, o_rd_addr, o_rd_data, o_ll_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and long-latency results into one registered rd
// write port through a 2-entry FIFO, and tracks pending long-latency destinations.
module wb_arbiter #(
    parameter int LL_DEPTH = 2,
    parameter int XLEN     = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    wb_arbiter_if.slave bus
);

    logic [1:0]      count_q, count_d;
    logic            head_q, head_d;
    logic            tail_q, tail_d;
    logic [4:0]      buf_addr_q [LL_DEPTH];
    logic [XLEN-1:0] buf_data_q [LL_DEPTH];
    logic [31:0]     sb_q, sb_d;
    logic            rd_wren_q, rd_wren_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;

    logic            ll_ready;
    logic            ll_xfer;
    logic            alu_sel;
    logic            pop;
    logic            bypass;
    logic            push;
    logic            ll_clr;
    logic [4:0]      ll_clr_rd;

    // Ready looks only at current occupancy, never at this cycle's pop.
    assign ll_ready = (count_q != 2'(LL_DEPTH));
    assign ll_xfer  = bus.i_ll_valid && ll_ready;
    assign alu_sel  = bus.i_alu_wren && (bus.i_alu_rd_addr != 5'd0);
    assign pop      = !alu_sel && (count_q != 2'd0);
    assign bypass   = !alu_sel && (count_q == 2'd0) && ll_xfer && (bus.i_ll_rd_addr != 5'd0);
    assign push     = ll_xfer && (bus.i_ll_rd_addr != 5'd0) && !bypass;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        rd_wren_d = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        ll_clr    = 1'b0;
        ll_clr_rd = 5'd0;

        if (alu_sel) begin
            rd_wren_d = 1'b1;
            rd_addr_d = bus.i_alu_rd_addr;
            rd_data_d = bus.i_alu_rd_data;
        end else if (pop) begin
            rd_wren_d = 1'b1;
            rd_addr_d = buf_addr_q[head_q];
            rd_data_d = buf_data_q[head_q];
            ll_clr    = 1'b1;
            ll_clr_rd = buf_addr_q[head_q];
        end else if (bypass) begin
            rd_wren_d = 1'b1;
            rd_addr_d = bus.i_ll_rd_addr;
            rd_data_d = bus.i_ll_rd_data;
            ll_clr    = 1'b1;
            ll_clr_rd = bus.i_ll_rd_addr;
        end

        head_d = head_q ^ pop;
        tail_d = tail_q ^ push;

        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Clear first, then set, so a same-cycle issue to the same rd keeps the bit.
        sb_d = sb_q;
        if (ll_clr) begin
            sb_d[ll_clr_rd] = 1'b0;
        end
        if (bus.i_ll_issue && (bus.i_ll_issue_rd != 5'd0)) begin
            sb_d[bus.i_ll_issue_rd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q   <= 2'd0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            sb_q      <= '0;
            rd_wren_q <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            sb_q      <= sb_d;
            rd_wren_q <= rd_wren_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // NOTE: buffer storage is not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_addr_q[tail_q] <= bus.i_ll_rd_addr;
            buf_data_q[tail_q] <= bus.i_ll_rd_data;
        end
    end

    assign bus.o_ll_ready    = ll_ready;
    assign bus.o_ll_count    = count_q;
    assign bus.o_rd_wren     = rd_wren_q;
    assign bus.o_rd_addr     = rd_addr_q;
    assign bus.o_rd_data     = rd_data_q;

    // An in-flight write on the output register still counts as pending.
    assign bus.o_rs1_pending = (bus.i_rs1_addr != 5'd0) &&
                               (sb_q[bus.i_rs1_addr] || (rd_wren_q && (rd_addr_q == bus.i_rs1_addr)));
    assign bus.o_rs2_pending = (bus.i_rs2_addr != 5'd0) &&
                               (sb_q[bus.i_rs2_addr] || (rd_wren_q && (rd_addr_q == bus.i_rs2_addr)));

endmodule
